// File: rtl/mem_access_stage.sv
// MEM stage data memory: multi-cycle, byte/half/word access with sign/zero extension and pipeline stall.
// Optional access statistics outputs are enabled by defining MEM_STATS_EN.
module mem_access_stage #(
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = 10,
    parameter int MEM_LAT = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        MisalignErr
`ifdef MEM_STATS_EN
    ,
    output logic [15:0] ReadCount,
    output logic [15:0] WriteCount,
    output logic [15:0] StallCycles
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic [3:0]        r_cnt, w_cnt_nxt;
    logic [ADDR_W+1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [1:0]        r_size;
    logic              r_uns;
    logic              r_is_wr;
    logic [31:0]       r_read_data;
    logic [31:0]       r_mem [DEPTH];

    logic              w_req, w_is_half, w_is_byte, w_misalign, w_accept;
    logic              w_stall, w_commit;
    logic [ADDR_W+1:0] w_op_addr;
    logic [31:0]       w_op_wdata;
    logic [1:0]        w_op_size;
    logic              w_op_uns, w_op_wr;
    logic [ADDR_W-1:0] w_idx;
    logic [3:0]        w_be;
    logic [31:0]       w_lane_data;
    logic [31:0]       w_rd_word;
    logic [7:0]        w_rd_byte;
    logic [15:0]       w_rd_half;
    logic [31:0]       w_rd_ext;
    logic              w_unused_bits;

    // Upper address bits are ignored so accesses alias modulo DEPTH.
    assign w_unused_bits = ^Address[31:ADDR_W+2];

    assign w_req      = MemRead | MemWrite;
    assign w_is_half  = (Size == 2'b01);
    assign w_is_byte  = (Size == 2'b10);
    assign w_misalign = w_req & ((w_is_half & Address[0]) |
                                 (!w_is_half & !w_is_byte & (Address[1:0] != 2'b00)));
    assign w_accept   = (r_state == S_IDLE) & w_req & !w_misalign;

    assign MisalignErr = w_misalign;
    assign Stall       = w_stall & Rst;
    assign ReadData    = r_read_data;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_stall   = 1'b1;
                    w_cnt_nxt = 4'(MEM_LAT - 1);
                    if (MEM_LAT == 1) begin
                        w_state_nxt = S_DONE;
                        w_commit    = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                w_stall   = 1'b1;
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = S_DONE;
                    w_commit    = 1'b1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // With MEM_LAT=1 the commit happens on the acceptance edge, before the latched copies exist.
    assign w_op_addr  = (r_state == S_IDLE) ? Address[ADDR_W+1:0] : r_addr;
    assign w_op_wdata = (r_state == S_IDLE) ? WriteData : r_wdata;
    assign w_op_size  = (r_state == S_IDLE) ? Size : r_size;
    assign w_op_uns   = (r_state == S_IDLE) ? Unsigned : r_uns;
    assign w_op_wr    = (r_state == S_IDLE) ? MemWrite : r_is_wr;
    assign w_idx      = w_op_addr[ADDR_W+1:2];

    always_comb begin
        w_be        = 4'b1111;
        w_lane_data = w_op_wdata;
        case (w_op_size)
            2'b01: begin
                w_be        = w_op_addr[1] ? 4'b1100 : 4'b0011;
                w_lane_data = {2{w_op_wdata[15:0]}};
            end
            2'b10: begin
                w_be        = 4'b0001 << w_op_addr[1:0];
                w_lane_data = {4{w_op_wdata[7:0]}};
            end
            default: ;
        endcase
    end

    assign w_rd_word = r_mem[w_idx];
    assign w_rd_byte = w_rd_word[{w_op_addr[1:0], 3'b000} +: 8];
    assign w_rd_half = w_op_addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];

    always_comb begin
        case (w_op_size)
            2'b01:   w_rd_ext = {{16{w_rd_half[15] & !w_op_uns}}, w_rd_half};
            2'b10:   w_rd_ext = {{24{w_rd_byte[7] & !w_op_uns}}, w_rd_byte};
            default: w_rd_ext = w_rd_word;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_addr      <= '0;
            r_wdata     <= 32'd0;
            r_size      <= 2'b00;
            r_uns       <= 1'b0;
            r_is_wr     <= 1'b0;
            r_read_data <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_addr  <= Address[ADDR_W+1:0];
                r_wdata <= WriteData;
                r_size  <= Size;
                r_uns   <= Unsigned;
                r_is_wr <= MemWrite;
            end
            if (w_commit && !w_op_wr) begin
                r_read_data <= w_rd_ext;
            end
        end
    end

    // NOTE: the memory array has no reset; only control state is cleared, contents survive Rst.
    always_ff @(posedge Clk) begin
        if (w_commit && w_op_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_lane_data[8*i +: 8];
                end
            end
        end
    end

`ifdef MEM_STATS_EN
    logic [15:0] r_rd_cnt, r_wr_cnt, r_stall_cnt;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_rd_cnt    <= 16'd0;
            r_wr_cnt    <= 16'd0;
            r_stall_cnt <= 16'd0;
        end else begin
            if (w_commit && !w_op_wr && (r_rd_cnt != 16'hFFFF)) r_rd_cnt <= r_rd_cnt + 16'd1;
            if (w_commit && w_op_wr && (r_wr_cnt != 16'hFFFF))  r_wr_cnt <= r_wr_cnt + 16'd1;
            if (w_stall && (r_stall_cnt != 16'hFFFF))           r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign ReadCount   = r_rd_cnt;
    assign WriteCount  = r_wr_cnt;
    assign StallCycles = r_stall_cnt;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected ReadData is queued when a request is driven
// and compared in the DONE cycle.
module tb_mem_access_stage;

    localparam int LAT = 2;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        MemRead = 1'b0, MemWrite = 1'b0, Unsigned = 1'b0;
    logic [1:0]  Size = 2'b00;
    logic [31:0] Address = 32'd0, WriteData = 32'd0;
    logic [31:0] ReadData;
    logic        Stall, MisalignErr;
`ifdef MEM_STATS_EN
    logic [15:0] ReadCount, WriteCount, StallCycles;
`endif

    mem_access_stage #(.DEPTH(1024), .ADDR_W(10), .MEM_LAT(LAT)) dut (
        .Clk(Clk), .Rst(Rst), .MemRead(MemRead), .MemWrite(MemWrite), .Size(Size),
        .Unsigned(Unsigned), .Address(Address), .WriteData(WriteData), .ReadData(ReadData),
        .Stall(Stall), .MisalignErr(MisalignErr)
`ifdef MEM_STATS_EN
        , .ReadCount(ReadCount), .WriteCount(WriteCount), .StallCycles(StallCycles)
`endif
    );

    always #5 Clk = ~Clk;

    int          cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] sb_q[$];
    logic [31:0] last_rd = 32'd0;
    int          done_cyc = 0;
    int          n_rd = 0, n_wr = 0, n_stall = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete access: expected ReadData is queued at drive time and popped in DONE.
    task automatic access(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp, input string tag);
        int n;
        @(negedge Clk);
        MemRead = rd; MemWrite = wr; Size = sz; Unsigned = uns;
        Address = addr; WriteData = wdata;
        if (rd && !wr) last_rd = exp;
        sb_q.push_back(last_rd);
        #1;
        n = 0;
        while (Stall && n < 40) begin
            n++;
            @(negedge Clk);
            #1;
        end
        check({tag, "_stall"}, n, LAT);
        check({tag, "_data"}, ReadData, sb_q.pop_front());
        done_cyc = cyc;
        n_stall += n;
        if (wr) n_wr++; else n_rd++;
        MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    initial begin
        int d1;
        #12;
        check("rst_rdata", ReadData, 32'd0);
        check("rst_stall", {31'd0, Stall}, 32'd0);
        check("rst_misalign", {31'd0, MisalignErr}, 32'd0);
        @(negedge Clk);
        Rst = 1'b1;

        access(1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, "sw10");
        access(1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, "lw10");

        access(1'b0, 1'b1, 2'b00, 1'b0, 32'h20, 32'h80FF7F01, 32'h0, "sw20");
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'h23, 32'h0, 32'hFFFFFF80, "lb23");
        access(1'b1, 1'b0, 2'b10, 1'b1, 32'h23, 32'h0, 32'h00000080, "lbu23");
        access(1'b1, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'hFFFF80FF, "lh22");
        access(1'b1, 1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 32'h00007F01, "lhu20");
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'h21, 32'h0, 32'h0000007F, "lb21");

        access(1'b0, 1'b1, 2'b00, 1'b0, 32'h20, 32'h11223344, 32'h0, "sw20b");
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'h21, 32'h000000AA, 32'h0, "sb21");
        access(1'b1, 1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 32'h1122AA44, "lw20");

        // Misaligned word load: no stall, no state change, ReadData held.
        @(negedge Clk);
        MemRead = 1'b1; Size = 2'b00; Address = 32'h22;
        #1;
        check("mis_lw_flag", {31'd0, MisalignErr}, 32'd1);
        check("mis_lw_stall", {31'd0, Stall}, 32'd0);
        @(negedge Clk);
        #1;
        check("mis_lw_stall2", {31'd0, Stall}, 32'd0);
        check("mis_lw_data", ReadData, last_rd);
        MemRead = 1'b0;
        // Misaligned halfword store must leave memory untouched.
        @(negedge Clk);
        MemWrite = 1'b1; Size = 2'b01; Address = 32'h21; WriteData = 32'h0000BEEF;
        #1;
        check("mis_sh_flag", {31'd0, MisalignErr}, 32'd1);
        check("mis_sh_stall", {31'd0, Stall}, 32'd0);
        @(negedge Clk);
        MemWrite = 1'b0;
        access(1'b1, 1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 32'h1122AA44, "lw20_after_mis");

        access(1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000BEEF, 32'h0, "sh22");
        access(1'b1, 1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 32'hBEEFAA44, "lw20_sh");

        // Reset in WAIT discards the pending store.
        access(1'b0, 1'b1, 2'b00, 1'b0, 32'h30, 32'hCAFEF00D, 32'h0, "sw30");
        access(1'b1, 1'b0, 2'b00, 1'b0, 32'h30, 32'h0, 32'hCAFEF00D, "lw30");
        @(negedge Clk);
        MemWrite = 1'b1; Size = 2'b00; Address = 32'h30; WriteData = 32'h12345678;
        #1;
        check("rstmid_stall_pre", {31'd0, Stall}, 32'd1);
        @(negedge Clk);
        Rst = 1'b0;
        #1;
        check("rstmid_stall", {31'd0, Stall}, 32'd0);
        check("rstmid_data", ReadData, 32'd0);
        last_rd = 32'd0;
        n_rd = 0; n_wr = 0; n_stall = 0;
        @(negedge Clk);
        MemWrite = 1'b0;
        Rst = 1'b1;
        access(1'b1, 1'b0, 2'b00, 1'b0, 32'h30, 32'h0, 32'hCAFEF00D, "lw30_after_rst");

        // Address wrap modulo DEPTH words.
        access(1'b0, 1'b1, 2'b00, 1'b0, 32'h4, 32'h5A5A0001, 32'h0, "sw4");
        access(1'b1, 1'b0, 2'b00, 1'b0, 32'h1004, 32'h0, 32'h5A5A0001, "lw1004");
        access(1'b0, 1'b1, 2'b00, 1'b0, 32'h1008, 32'h0BADF00D, 32'h0, "sw1008");
        access(1'b1, 1'b0, 2'b00, 1'b0, 32'h8, 32'h0, 32'h0BADF00D, "lw8");

        // Read and write together: write wins, ReadData unchanged.
        access(1'b1, 1'b1, 2'b00, 1'b0, 32'h40, 32'h77777777, 32'h0, "rw40");
        access(1'b1, 1'b0, 2'b00, 1'b0, 32'h40, 32'h0, 32'h77777777, "lw40");

        // Back-to-back loads restart immediately after DONE.
        access(1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, "b2b_a");
        d1 = done_cyc;
        access(1'b1, 1'b0, 2'b10, 1'b1, 32'h20, 32'h0, 32'h00000044, "b2b_b");
        check("b2b_gap", done_cyc - d1, LAT + 1);

`ifdef MEM_STATS_EN
        @(negedge Clk);
        check("stat_reads", {16'd0, ReadCount}, n_rd);
        check("stat_writes", {16'd0, WriteCount}, n_wr);
        check("stat_stalls", {16'd0, StallCycles}, n_stall);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the pipelined datapath. Sits between the EX/MEM pipeline register and the MEM/WB register, and produces the ReadData that MEM/WB captures.
- Implements a word-organised data memory with multi-cycle latency, byte/halfword/word access, sign/zero extension, and a Stall output that freezes the upstream pipeline while an access is in flight.

Parameters:
- DEPTH, 1024, number of 32-bit words in the memory array.
- ADDR_W, 10, word-index width; must equal log2(DEPTH).
- MEM_LAT, 2, cycles from request acceptance to completion; legal range 1..15.

Ports:
- Clk  input  1  clock; all state changes on its rising edge.
- Rst  input  1  asynchronous, active-low reset.
- MemRead  input  1  load request (from EX/MEM).
- MemWrite  input  1  store request (from EX/MEM).
- Size  input  2  access size: 00 word, 01 halfword, 10 byte, 11 treated as word.
- Unsigned  input  1  load extension: 1 zero-extends, 0 sign-extends (byte/half only).
- Address  input  32  byte address (ALU result).
- WriteData  input  32  store data; low byte/half used for sub-word stores.
- ReadData  output  32  registered, extended load result for MEM/WB.
- Stall  output  1  freezes PC, IF/ID, ID/EX and EX/MEM while high.
- MisalignErr  output  1  combinational flag for a misaligned request.

Behaviour:
- Reset (Rst low, asynchronous): state IDLE, wait counter 0, ReadData 0, Stall forced 0, any pending access discarded. Memory contents are not reset.
- Word index is Address[ADDR_W+1:2]. Higher address bits are ignored, so accesses wrap modulo DEPTH.
- Byte lanes are little-endian: byte offset 0 maps to bits 7:0, and halfword offset 0 maps to bits 15:0.
- Misaligned request: halfword with Address[0]=1, or word with Address[1:0]!=0.
  - MisalignErr=1; no access, no stall, no state change.
  - Memory is not written and ReadData holds its value.
- MemRead and MemWrite both high: the access is a write only; ReadData is unchanged.
- State IDLE:
  - Aligned request present: Stall=1 (combinational); load the counter with MEM_LAT-1.
  - Next state is DONE if MEM_LAT=1, otherwise WAIT.
  - No request: Stall=0; stay in IDLE.
- State WAIT:
  - Stall=1; decrement the counter each cycle.
  - Move to DONE on the edge where the counter is 1 at the start of the cycle.
  - Upstream holds all request inputs stable while Stall=1; the block latches Address, WriteData, Size, Unsigned and the request type at acceptance and uses the latched copies.
- Entry into DONE (same edge): a write commits its byte-enabled lanes; a read loads ReadData with the extended value.
- State DONE:
  - Stall=0, so the pipeline advances and MEM/WB captures ReadData at the end of this cycle.
  - Next state is IDLE unconditionally. Inputs seen during DONE are never treated as a new request.
- Total stall per access = MEM_LAT cycles; the access occupies MEM_LAT+1 cycles including DONE.
- Extension:
  - Byte: sign = bit 7 of the selected byte unless Unsigned=1.
  - Half: sign = bit 15 of the selected half unless Unsigned=1.
  - Word: returned unmodified.
- Reset asserted mid-access (WAIT or DONE entry pending): the write is not committed, ReadData goes to 0, and the FSM goes to IDLE.

Optional Feature:
- Macro MEM_STATS_EN.
- When defined, adds three outputs:
  - ReadCount [15:0]: completed reads.
  - WriteCount [15:0]: completed writes.
  - StallCycles [15:0]: cycles with Stall=1.
- All three counters saturate at 16'hFFFF, reset to 0 on Rst, and count at the DONE-entry edge (reads/writes) or each stalled cycle.
- When undefined: these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Word store then load (MEM_LAT=2): store 32'hDEADBEEF at 0x10, then load word 0x10 → Stall high exactly 2 cycles per access; ReadData=32'hDEADBEEF in the DONE cycle.
- Sub-word loads on word 32'h80FF7F01 at 0x20:
  - lb 0x23 → 32'hFFFFFF80.
  - lbu 0x23 → 32'h00000080.
  - lh 0x22 → 32'hFFFF80FF.
  - lhu 0x20 → 32'h00007F01.
- Byte store: sb WriteData=32'h000000AA to 0x21 over word 32'h11223344 → later lw 0x20 returns 32'h1122AA44.
- Misaligned: lw at 0x22 → MisalignErr=1, Stall=0, ReadData unchanged, FSM stays IDLE. Same for sh at 0x21, with memory unchanged.
- Reset mid-access: sw 32'h12345678 to 0x30, drop Rst in WAIT → Stall=0 and ReadData=0 immediately; after release, lw 0x30 returns the prior contents.
- Wrap/priority:
  - Address 0x1000+0x4 (DEPTH=1024) aliases word 1.
  - MemRead=MemWrite=1 writes and leaves ReadData unchanged.
  - Back-to-back loads restart from IDLE after DONE with no lost cycle.
